// File: rtl/cnn_pkg.sv
// Shared CNN definitions: Q4.16 data format, layer-2 memory select, FC state encoding,
// and the rounding/saturation helpers used by the output stages.
package cnn_pkg;
    localparam int DW   = 20;
    localparam int FRAC = 16;
    localparam int ACCW = 48;
    localparam int CAW  = 12;
    localparam int WAW  = 14;
    localparam int OIW  = 2;
    localparam logic [2:0] CSEL_L2 = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_BIAS, S_DRAIN, S_POST, S_WRITE, S_DONE
    } fc_state_t;

    // Clamp a wide signed value into the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat20(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] hi, lo;
        hi = ACCW'(2**(DW-1)-1);
        lo = ~hi;
        if (v > hi)
            return {1'b0, {(DW-1){1'b1}}};
        else if (v < lo)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
    endfunction

    // Drop FRAC fraction bits with round-half-up; result stays full width for saturation.
    function automatic logic signed [ACCW-1:0] round_q16(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] sh, half;
        sh   = acc >>> FRAC;
        half = {{(ACCW-1){1'b0}}, acc[FRAC-1]};
        return sh + half;
    endfunction
endpackage

// File: rtl/fc_mac.sv
// Three-stage multiply-accumulate: operand register, full-width product register,
// then accumulate. Only clr empties the accumulator.
module fc_mac
    import cnn_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);
    localparam int STAGES = 1;

    logic [STAGES:0]         vld_pipe;
    logic signed [DW-1:0]    a_q, b_q;
    logic signed [2*DW-1:0]  prod_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            acc      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], en};
            if (en) begin
                a_q <= a;
                b_q <= b;
            end
            if (vld_pipe[0])
                prod_q <= a_q * b_q;
            if (clr)
                acc <= '0;
            else if (vld_pipe[STAGES])
                acc <= acc + ACCW'(prod_q);
        end
    end
endmodule

// File: rtl/fc_layer.sv
// Fully-connected output stage: streams the flattened feature map once per neuron,
// accumulates the dot product, then applies round, saturate, bias and ReLU.
module fc_layer
    import cnn_pkg::*;
#(
    parameter int N_IN    = 2048,
    parameter int NUM_OUT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            crd,
    output logic [2:0]      csel,
    output logic [CAW-1:0]  caddr_rd,
    input  logic [DW-1:0]   cdata_rd,
    output logic [WAW-1:0]  waddr,
    input  logic [DW-1:0]   wdata,
    output logic            ovalid,
    output logic [OIW-1:0]  oidx,
    output logic [DW-1:0]   odata
);
    localparam int IW = $clog2(N_IN);
    localparam int NW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_OUT - 1);

    fc_state_t               state, state_nx;
    logic [IW-1:0]           i_cnt;
    logic [NW-1:0]           n_cnt;
    logic                    dcnt;
    logic                    mac_clr;
    logic signed [ACCW-1:0]  acc;
    logic signed [DW-1:0]    bias_q, r_sat, y_sat;
    logic [DW-1:0]           odata_q;

    fc_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (crd),
        .clr   (mac_clr),
        .a     (cdata_rd),
        .b     (wdata),
        .acc   (acc)
    );

    always_comb begin
        state_nx = state;
        mac_clr  = 1'b0;
        case (state)
            S_IDLE:  if (start) begin
                         state_nx = S_LOAD;
                         mac_clr  = 1'b1;
                     end
            S_LOAD:  if (i_cnt == I_LAST) state_nx = S_BIAS;
            S_BIAS:  state_nx = S_DRAIN;
            S_DRAIN: if (dcnt) state_nx = S_POST;
            S_POST:  state_nx = S_WRITE;
            S_WRITE: if (n_cnt == N_LAST) state_nx = S_DONE;
                     else begin
                         state_nx = S_LOAD;
                         mac_clr  = 1'b1;
                     end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // The feature index holds its last value until the next neuron's LOAD entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_cnt   <= '0;
            n_cnt   <= '0;
            dcnt    <= 1'b0;
            bias_q  <= '0;
            odata_q <= '0;
        end else begin
            if (mac_clr)
                i_cnt <= '0;
            else if (state == S_LOAD && i_cnt != I_LAST)
                i_cnt <= i_cnt + 1'b1;
            if (state == S_IDLE && start)
                n_cnt <= '0;
            else if (state == S_WRITE && n_cnt != N_LAST)
                n_cnt <= n_cnt + 1'b1;
            dcnt <= (state == S_DRAIN) ? ~dcnt : 1'b0;
            if (state == S_BIAS)
                bias_q <= wdata;
            if (state == S_POST)
                odata_q <= y_sat[DW-1] ? '0 : y_sat;
        end
    end

    assign r_sat = sat20(round_q16(acc));
    assign y_sat = sat20(ACCW'(r_sat) + ACCW'(bias_q));

    // N_IN is a power of two, so neuron*N_IN+i is a plain concatenation.
    assign crd      = (state == S_LOAD);
    assign csel     = crd ? CSEL_L2 : 3'b000;
    assign caddr_rd = CAW'(i_cnt);
    assign waddr    = (state == S_BIAS) ? WAW'(NUM_OUT * N_IN) + WAW'(n_cnt)
                                        : WAW'({n_cnt, i_cnt});
    assign ovalid   = (state == S_WRITE);
    assign oidx     = OIW'(n_cnt);
    assign odata    = odata_q;
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE);
endmodule
